stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  Datapath stage downstream of the stopwatch control FSM. Consumes its 3-bit
//  command each CLK cycle and maintains the 0..9999 stopwatch count.
//  A tick prescaler paces INC/DEC. The count feeds back to the FSM (counter
//  input). A sequential double-dabble converter produces 4 BCD digits for the display.
// PARAMETERS
//  TICK_DIV  1000000  CLK cycles per count step (100 MHz -> 10 ms); must be >= 2
//  MAX_VAL   9999     upper count limit; clamp value for LOAD_EXT
// PORTS
//  CLK        in   1   system clock; all logic on posedge
//  reset      in   1   synchronous, active-high block reset
//  cmd        in   3   000 HOLD, 001 INC, 010 DEC, 011 LOAD_0, 100 LOAD_9999, 101 LOAD_EXT
//  ext_val    in   14  external preset (switches), binary
//  count      out  14  current count, binary; drives FSM counter input
//  tick       out  1   1-cycle pulse when prescaler wraps (a step is applied)
//  bcd        out  16  {thousands,hundreds,tens,ones} of count, 4 bits each
//  bcd_valid  out  1   1 when bcd equals current count
// BEHAVIOUR
//  Reset: count=0, tick=0, bcd=16'h0000, bcd_valid=1, prescaler=0, converter IDLE,
//   pending=0.
//  Prescaler (pre, width clog2(TICK_DIV)):
//   - cmd INC/DEC: pre increments; when pre==TICK_DIV-1, pre<=0 and tick<=1 next cycle.
//   - HOLD: pre frozen (pause keeps partial interval); tick=0.
//   - any LOAD: pre<=0; tick=0.
//   - cmd 110/111: treated exactly as HOLD.
//  Count update (registered, 1-cycle latency from cmd):
//   - LOAD_0 -> 0; LOAD_9999 -> MAX_VAL.
//   - LOAD_EXT -> ext_val, or MAX_VAL if ext_val>MAX_VAL.
//   - INC on a cycle where pre==TICK_DIV-1: count+1, saturating at MAX_VAL.
//   - DEC on the same wrap condition: count-1, saturating at 0.
//   - Otherwise count holds. Loads apply every cycle the cmd is present, no tick needed.
//  tick asserts in the same cycle count shows the stepped value, even if saturated.
//  BCD converter FSM: IDLE -> SHIFT (14 cycles) -> LATCH -> IDLE.
//   - IDLE: if count != last converted value, capture count and clear the scratch
//     register. bcd_valid<=0. Go to SHIFT.
//   - SHIFT: each cycle add 3 to every BCD nibble >=5, then shift left 1 with the
//     next binary MSB. Exactly 14 cycles.
//   - LATCH: bcd<=scratch. Go to IDLE.
//   - Latency from capture to bcd update: 16 cycles.
//   - bcd_valid<=1 in LATCH only if count equals the captured value. Otherwise it
//     stays 0 and IDLE restarts on the next cycle.
//   - count changes during SHIFT do not abort; the newest value is converted next.
//   - bcd holds its old value (no glitching) while a conversion runs.
//  reset mid-conversion or mid-interval: all state returns to reset values next cycle.
//  Simultaneous reset with any cmd: reset wins.
// TESTING (sim with TICK_DIV=4)
//  1. reset 1 cycle, cmd=HOLD 20 cycles -> count=0, tick never 1, bcd=0000, bcd_valid=1.
//  2. LOAD_0 then INC 12 cycles -> tick every 4th cycle; count 1,2,3 at each tick.
//     bcd reaches 0003 16 cycles after the last change.
//  3. INC 2 cycles, HOLD 10, INC 2 -> exactly one tick, on the 2nd cycle after
//     resume; count=1.
//  4. LOAD_EXT ext_val=12000 -> count=9999. Then INC 8 cycles -> 2 ticks, count
//     stays 9999, bcd=9999.
//  5. LOAD_EXT ext_val=2 then DEC 16 cycles -> count 1, 0, 0, 0; never wraps to 16383.
//  6. LOAD_9999, 5 cycles later LOAD_0, then reset asserted during SHIFT -> next
//     cycle count=0, bcd=0000, bcd_valid=1.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch datapath: prescaled 0..MAX_VAL up/down counter driven by the control
// FSM's command, plus a sequential double-dabble converter feeding the display.
module stopwatch_counter #(
  parameter int TICK_DIV = 1000000,
  parameter int MAX_VAL  = 9999
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [2:0]  cmd,
  input  logic [13:0] ext_val,
  output logic [13:0] count,
  output logic        tick,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [1:0]  dbg_state
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [13:0] MAX_C = 14'(MAX_VAL);

  localparam logic [2:0] CMD_INC       = 3'd1;
  localparam logic [2:0] CMD_DEC       = 3'd2;
  localparam logic [2:0] CMD_LOAD_0    = 3'd3;
  localparam logic [2:0] CMD_LOAD_9999 = 3'd4;
  localparam logic [2:0] CMD_LOAD_EXT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } conv_state_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [13:0]      count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap;

  conv_state_e      state_q;
  logic [13:0]      last_q;
  logic [13:0]      bin_q;
  logic [15:0]      dig_q;
  logic [14:0]      dig_adj;
  logic [3:0]       shift_cnt_q;
  logic [15:0]      bcd_q;
  logic             bcd_valid_q;

  assign wrap = (pre_q == PRE_LAST);

  // Steps happen only on a prescaler wrap; loads bypass the prescaler and restart it.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    case (cmd)
      CMD_INC: begin
        if (wrap) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (count_q < MAX_C) count_d = count_q + 14'd1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      CMD_DEC: begin
        if (wrap) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (count_q != 14'd0) count_d = count_q - 14'd1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      CMD_LOAD_0: begin
        pre_d   = '0;
        count_d = 14'd0;
      end
      CMD_LOAD_9999: begin
        pre_d   = '0;
        count_d = MAX_C;
      end
      CMD_LOAD_EXT: begin
        pre_d   = '0;
        count_d = (ext_val > MAX_C) ? MAX_C : ext_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pre_q   <= '0;
      count_q <= 14'd0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  // Add-3 on the lower three digits; the thousands digit never reaches 5 before
  // a shift because the count is clamped to four decimal digits.
  always_comb begin
    dig_adj = dig_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= 14'd0;
      bin_q       <= 14'd0;
      dig_q       <= 16'd0;
      shift_cnt_q <= 4'd0;
      bcd_q       <= 16'h0000;
      bcd_valid_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != last_q) begin
            last_q      <= count_q;
            bin_q       <= count_q;
            dig_q       <= 16'd0;
            shift_cnt_q <= 4'd0;
            bcd_valid_q <= 1'b0;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          dig_q       <= {dig_adj, bin_q[13]};
          bin_q       <= {bin_q[12:0], 1'b0};
          shift_cnt_q <= shift_cnt_q + 4'd1;
          if (shift_cnt_q == 4'd13) state_q <= S_LATCH;
        end
        S_LATCH: begin
          bcd_q       <= dig_q;
          bcd_valid_q <= (count_q == last_q);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign tick      = tick_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: per-cycle scoreboard against an arithmetic model,
// directed scenarios followed by randomized command traffic.
module tb_stopwatch_counter;

  localparam int TD = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic [2:0]  cmd;
  logic [13:0] ext_val;
  logic [13:0] count;
  logic        tick;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [1:0]  dbg_state;

  stopwatch_counter #(.TICK_DIV(TD), .MAX_VAL(9999)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmd       (cmd),
    .ext_val   (ext_val),
    .count     (count),
    .tick      (tick),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int tick_seen = 0;

  // Reference state: counter value, position in the tick interval, and the
  // display pipeline as "busy for N more cycles, then show digits of last".
  int          m_count, m_pre, m_busy, m_last;
  logic        m_tick, m_valid;
  logic [15:0] m_bcd;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step(input logic r, input logic [2:0] c, input logic [13:0] e);
    int old;
    reset   = r;
    cmd     = c;
    ext_val = e;
    old     = m_count;
    if (r) begin
      m_count = 0; m_pre = 0; m_tick = 1'b0; m_bcd = 16'h0000;
      m_valid = 1'b1; m_last = 0; m_busy = 0;
    end else begin
      m_tick = 1'b0;
      case (c)
        3'd1, 3'd2: begin
          if (m_pre == TD - 1) begin
            m_pre  = 0;
            m_tick = 1'b1;
            if (c == 3'd1) m_count = (m_count < 9999) ? m_count + 1 : 9999;
            else           m_count = (m_count > 0) ? m_count - 1 : 0;
          end else begin
            m_pre++;
          end
        end
        3'd3: begin m_pre = 0; m_count = 0; end
        3'd4: begin m_pre = 0; m_count = 9999; end
        3'd5: begin m_pre = 0; m_count = (int'(e) > 9999) ? 9999 : int'(e); end
        default: ;
      endcase
      if (m_busy == 0) begin
        if (old != m_last) begin
          m_last  = old;
          m_valid = 1'b0;
          m_busy  = 15;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_bcd   = to_bcd(m_last);
          m_valid = (old == m_last);
        end
      end
    end
    exp_q.push_back({14'(m_count), m_tick, m_bcd, m_valid});
    @(posedge CLK);
    #2;
  endtask

  task automatic monitor_loop();
    logic [31:0] exp;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        total++;
        if ({count, tick, bcd, bcd_valid} !== exp) begin
          bad++;
          $display("FAIL cycle_check t=%0t got count=%0d tick=%0b bcd=%h valid=%0b exp count=%0d tick=%0b bcd=%h valid=%0b",
                   $time, count, tick, bcd, bcd_valid, exp[31:18], exp[17], exp[16:1], exp[0]);
        end
        if (tick === 1'b1) tick_seen++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; cmd = 3'd0; ext_val = 14'd0;
    fork
      monitor_loop();
    join_none

    // Reset then idle.
    step(1'b1, 3'd0, 14'd0);
    tick_seen = 0;
    repeat (20) step(1'b0, 3'd0, 14'd0);
    chk("t1_ticks", tick_seen, 0);
    chk("t1_count", int'(count), 0);
    chk("t1_bcd", int'(bcd), 0);
    chk("t1_valid", int'(bcd_valid), 1);

    // Counting up.
    step(1'b0, 3'd3, 14'd0);
    tick_seen = 0;
    repeat (12) step(1'b0, 3'd1, 14'd0);
    chk("t2_ticks", tick_seen, 3);
    chk("t2_count", int'(count), 3);
    repeat (40) step(1'b0, 3'd0, 14'd0);
    chk("t2_bcd", int'(bcd), 16'h0003);
    chk("t2_valid", int'(bcd_valid), 1);

    // Pause keeps the partial interval.
    step(1'b0, 3'd3, 14'd0);
    tick_seen = 0;
    repeat (2) step(1'b0, 3'd1, 14'd0);
    repeat (10) step(1'b0, 3'd0, 14'd0);
    chk("t3_no_tick_yet", tick_seen, 0);
    repeat (2) step(1'b0, 3'd1, 14'd0);
    chk("t3_ticks", tick_seen, 1);
    chk("t3_count", int'(count), 1);

    // External preset clamp and upper saturation.
    step(1'b0, 3'd5, 14'd12000);
    chk("t4_clamp", int'(count), 9999);
    tick_seen = 0;
    repeat (8) step(1'b0, 3'd1, 14'd0);
    chk("t4_ticks", tick_seen, 2);
    chk("t4_count", int'(count), 9999);
    repeat (40) step(1'b0, 3'd0, 14'd0);
    chk("t4_bcd", int'(bcd), 16'h9999);

    // Lower saturation.
    step(1'b0, 3'd5, 14'd2);
    tick_seen = 0;
    repeat (16) step(1'b0, 3'd2, 14'd0);
    chk("t5_ticks", tick_seen, 4);
    chk("t5_count", int'(count), 0);
    repeat (40) step(1'b0, 3'd0, 14'd0);

    // Reset in the middle of a conversion.
    step(1'b0, 3'd4, 14'd0);
    repeat (4) step(1'b0, 3'd0, 14'd0);
    step(1'b0, 3'd3, 14'd0);
    repeat (3) step(1'b0, 3'd0, 14'd0);
    step(1'b1, 3'd1, 14'd0);
    chk("t6_count", int'(count), 0);
    chk("t6_bcd", int'(bcd), 0);
    chk("t6_valid", int'(bcd_valid), 1);

    // Randomized traffic, including reserved commands and occasional reset.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      step(1'b0, 3'd1, 14'd0);
      else if (r < 50) step(1'b0, 3'd2, 14'd0);
      else if (r < 66) step(1'b0, 3'd0, 14'd0);
      else if (r < 70) step(1'b0, 3'($urandom_range(6, 7)), 14'd0);
      else if (r < 75) step(1'b0, 3'd3, 14'd0);
      else if (r < 79) step(1'b0, 3'd4, 14'd0);
      else if (r < 88) step(1'b0, 3'd5, 14'($urandom_range(0, 16383)));
      else if (r < 90) step(1'b1, 3'($urandom_range(0, 7)), 14'($urandom_range(0, 16383)));
      else             repeat ($urandom_range(5, 25)) step(1'b0, 3'd0, 14'd0);
    end
    repeat (40) step(1'b0, 3'd0, 14'd0);
    chk("final_bcd", int'(bcd), int'(to_bcd(int'(count))));
    chk("final_valid", int'(bcd_valid), 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
